// File: rtl/dm_arb_pkg.sv
// Shared encodings for the data-memory port arbiter: memory access types,
// FSM state enum and the alignment check applied when a command is latched.
package dm_arb_pkg;

    localparam logic [1:0] MT_INVALID = 2'b00;
    localparam logic [1:0] MT_BYTE    = 2'b01;
    localparam logic [1:0] MT_HALF    = 2'b10;
    localparam logic [1:0] MT_WORD    = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } arb_state_e;

    // A command is in error when its type is invalid or its address is not
    // naturally aligned for the access size.
    function automatic logic cmd_is_bad(input logic [1:0] m_type, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (m_type)
            MT_INVALID: bad = 1'b1;
            MT_HALF:    bad = addr_lo[0];
            MT_WORD:    bad = |addr_lo;
            default:    bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_port_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone eligible port wins outright; on a tie the
// port that was not served last wins.
module rr_arb2 (
    input  logic [1:0] eligible,
    input  logic       last,
    output logic       winner
);

    // Tie goes to the port opposite the last grant.
    always_comb begin
        winner = 1'b0;
        if (eligible == 2'b11) begin
            winner = ~last;
        end else begin
            winner = eligible[1];
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Data-memory arbiter between the CPU memory stage (port 0) and the
// debug/DMA port (port 1). One latched command is presented to memory per
// SERVE cycle and acknowledged combinationally to its owner in that cycle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | memory side inactive, all memory-side outputs at zero
// ST_SERVE | latched command driven to memory, owner acked this cycle
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int NPORT = 2
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req_0,
    input  logic             we_0,
    input  logic [1:0]       type_0,
    input  logic [31:0]      addr_0,
    input  logic [31:0]      wdata_0,
    input  logic [31:0]      pc_0,
    output logic             ack_0,
    output logic             err_0,
    output logic [31:0]      rdata_0,

    input  logic             req_1,
    input  logic             we_1,
    input  logic [1:0]       type_1,
    input  logic [31:0]      addr_1,
    input  logic [31:0]      wdata_1,
    input  logic [31:0]      pc_1,
    output logic             ack_1,
    output logic             err_1,
    output logic [31:0]      rdata_1,

    output logic             dm_scr,
    output logic [1:0]       dm_M_type,
    output logic [31:0]      dm_addr,
    output logic [31:0]      dm_din,
    output logic [31:0]      dm_pc,
    input  logic [31:0]      dm_dout,

    output logic [CNT_W-1:0] gcnt0,
    output logic [CNT_W-1:0] gcnt1
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    arb_state_e        state;
    logic              owner;
    logic              last;
    logic              cmd_we;
    logic [1:0]        cmd_type;
    logic [31:0]       cmd_addr;
    logic [31:0]       cmd_wdata;
    logic [31:0]       cmd_pc;
    logic              cmd_err;

    logic              serving;
    logic [NPORT-1:0]  owned;
    logic [NPORT-1:0]  eligible;
    logic              winner;

    logic              sel_we;
    logic [1:0]        sel_type;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic [31:0]       sel_pc;

    assign serving = (state == ST_SERVE);

    // The owner's request is masked during its ack cycle so a held req is
    // not re-granted back-to-back; it reappears as a new transaction later.
    always_comb begin
        owned = '0;
        if (serving) begin
            owned[owner] = 1'b1;
        end
        eligible = {req_1, req_0} & ~owned;
    end

    rr_arb2 u_rr_arb2 (
        .eligible (eligible),
        .last     (last),
        .winner   (winner)
    );

    // Route the winning port's command toward the command register.
    always_comb begin
        if (winner) begin
            sel_we    = we_1;
            sel_type  = type_1;
            sel_addr  = addr_1;
            sel_wdata = wdata_1;
            sel_pc    = pc_1;
        end else begin
            sel_we    = we_0;
            sel_type  = type_0;
            sel_addr  = addr_0;
            sel_wdata = wdata_0;
            sel_pc    = pc_0;
        end
    end

    // FSM, owner/round-robin pointer and command register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            cmd_we    <= 1'b0;
            cmd_type  <= MT_INVALID;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_pc    <= '0;
            cmd_err   <= 1'b0;
        end else if (|eligible) begin
            state     <= ST_SERVE;
            owner     <= winner;
            last      <= winner;
            cmd_we    <= sel_we;
            cmd_type  <= sel_type;
            cmd_addr  <= sel_addr;
            cmd_wdata <= sel_wdata;
            cmd_pc    <= sel_pc;
            cmd_err   <= cmd_is_bad(sel_type, sel_addr[1:0]);
        end else if (serving) begin
            state     <= ST_IDLE;
        end
    end

    // Per-port completed-grant counters, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gcnt0 <= '0;
            gcnt1 <= '0;
        end else if (serving) begin
            if (!owner && (gcnt0 != '1)) begin
                gcnt0 <= gcnt0 + CNT_ONE;
            end
            if (owner && (gcnt1 != '1)) begin
                gcnt1 <= gcnt1 + CNT_ONE;
            end
        end
    end

    // Memory-side drive; errored commands never assert the write strobe.
    always_comb begin
        dm_scr    = 1'b0;
        dm_M_type = MT_INVALID;
        dm_addr   = '0;
        dm_din    = '0;
        dm_pc     = '0;
        if (serving) begin
            dm_scr    = cmd_we & ~cmd_err;
            dm_M_type = cmd_type;
            dm_addr   = cmd_addr;
            dm_din    = cmd_wdata;
            dm_pc     = cmd_pc;
        end
    end

    // Requester-side response goes to the owner only.
    always_comb begin
        ack_0   = 1'b0;
        err_0   = 1'b0;
        rdata_0 = '0;
        ack_1   = 1'b0;
        err_1   = 1'b0;
        rdata_1 = '0;
        if (serving) begin
            if (owner) begin
                ack_1   = 1'b1;
                err_1   = cmd_err;
                rdata_1 = dm_dout;
            end else begin
                ack_0   = 1'b1;
                err_0   = cmd_err;
                rdata_0 = dm_dout;
            end
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;

    logic        clk;
    logic        reset;
    logic        req_0, we_0, req_1, we_1;
    logic [1:0]  type_0, type_1;
    logic [31:0] addr_0, wdata_0, pc_0, addr_1, wdata_1, pc_1;
    logic        ack_0, err_0, ack_1, err_1;
    logic [31:0] rdata_0, rdata_1;
    logic        dm_scr;
    logic [1:0]  dm_M_type;
    logic [31:0] dm_addr, dm_din, dm_pc, dm_dout;
    logic [3:0]  gcnt0, gcnt1;

    logic [31:0] mem [16];

    int tests_run = 0;
    int tests_failed = 0;

    dm_port_arbiter #(.CNT_W(4), .NPORT(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_0     (req_0),
        .we_0      (we_0),
        .type_0    (type_0),
        .addr_0    (addr_0),
        .wdata_0   (wdata_0),
        .pc_0      (pc_0),
        .ack_0     (ack_0),
        .err_0     (err_0),
        .rdata_0   (rdata_0),
        .req_1     (req_1),
        .we_1      (we_1),
        .type_1    (type_1),
        .addr_1    (addr_1),
        .wdata_1   (wdata_1),
        .pc_1      (pc_1),
        .ack_1     (ack_1),
        .err_1     (err_1),
        .rdata_1   (rdata_1),
        .dm_scr    (dm_scr),
        .dm_M_type (dm_M_type),
        .dm_addr   (dm_addr),
        .dm_din    (dm_din),
        .dm_pc     (dm_pc),
        .dm_dout   (dm_dout),
        .gcnt0     (gcnt0),
        .gcnt1     (gcnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed memory model: combinational read of the full word,
    // write on the clock edge when dm_scr is high.
    assign dm_dout = mem[dm_addr[5:2]];

    always @(posedge clk) begin
        if (dm_scr) begin
            case (dm_M_type)
                2'b11: mem[dm_addr[5:2]] <= dm_din;
                2'b10: begin
                    if (dm_addr[1]) mem[dm_addr[5:2]][31:16] <= dm_din[15:0];
                    else            mem[dm_addr[5:2]][15:0]  <= dm_din[15:0];
                end
                2'b01: mem[dm_addr[5:2]][8*dm_addr[1:0] +: 8] <= dm_din[7:0];
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic r, input logic w, input logic [1:0] t,
                          input logic [31:0] a, input logic [31:0] d);
        req_0 = r; we_0 = w; type_0 = t; addr_0 = a; wdata_0 = d; pc_0 = 32'h100 + a;
    endtask

    task automatic drive1(input logic r, input logic w, input logic [1:0] t,
                          input logic [31:0] a, input logic [31:0] d);
        req_1 = r; we_1 = w; type_1 = t; addr_1 = a; wdata_1 = d; pc_1 = 32'h200 + a;
    endtask

    initial begin
        reset = 1'b1;
        drive0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        #2;
        check("rst_ack0",  {31'b0, ack_0}, 32'h0);
        check("rst_ack1",  {31'b0, ack_1}, 32'h0);
        check("rst_scr",   {31'b0, dm_scr}, 32'h0);
        check("rst_addr",  dm_addr, 32'h0);
        check("rst_gcnt0", {28'b0, gcnt0}, 32'h0);
        tick();
        reset = 1'b0;

        // Word write from port 0: one-cycle latency to ack.
        drive0(1'b1, 1'b1, 2'b11, 32'h10, 32'hDEADBEEF);
        tick();
        check("wr_scr",   {31'b0, dm_scr}, 32'h1);
        check("wr_addr",  dm_addr, 32'h10);
        check("wr_din",   dm_din, 32'hDEADBEEF);
        check("wr_pc",    dm_pc, 32'h110);
        check("wr_ack0",  {31'b0, ack_0}, 32'h1);
        check("wr_ack1",  {31'b0, ack_1}, 32'h0);
        check("wr_err0",  {31'b0, err_0}, 32'h0);
        drive0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        check("wr_gcnt0", {28'b0, gcnt0}, 32'h1);
        check("wr_idle",  {31'b0, ack_0}, 32'h0);
        check("wr_mem",   mem[4], 32'hDEADBEEF);

        // Write 0x11223344 to 0x10, then byte read at 0x13 returns the word.
        drive0(1'b1, 1'b1, 2'b11, 32'h10, 32'h11223344);
        tick();
        drive0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        drive0(1'b1, 1'b0, 2'b01, 32'h13, 32'h0);
        tick();
        check("rdb_ack0",  {31'b0, ack_0}, 32'h1);
        check("rdb_rdata", rdata_0, 32'h11223344);
        check("rdb_err0",  {31'b0, err_0}, 32'h0);
        check("rdb_scr",   {31'b0, dm_scr}, 32'h0);
        check("rdb_type",  {30'b0, dm_M_type}, 32'h1);
        drive0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        tick();

        // Invalid type flagged as error.
        drive0(1'b1, 1'b0, 2'b00, 32'h8, 32'h0);
        tick();
        check("inv_ack0", {31'b0, ack_0}, 32'h1);
        check("inv_err0", {31'b0, err_0}, 32'h1);
        drive0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        check("inv_gcnt0", {28'b0, gcnt0}, 32'h4);

        // Port 1: preload 0x20, misaligned half write must not reach memory.
        drive1(1'b1, 1'b1, 2'b11, 32'h20, 32'h55AA55AA);
        tick();
        check("p1_ack1", {31'b0, ack_1}, 32'h1);
        check("p1_ack0", {31'b0, ack_0}, 32'h0);
        drive1(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        drive1(1'b1, 1'b1, 2'b10, 32'h21, 32'hCAFEF00D);
        tick();
        check("mis_ack1", {31'b0, ack_1}, 32'h1);
        check("mis_err1", {31'b0, err_1}, 32'h1);
        check("mis_scr",  {31'b0, dm_scr}, 32'h0);
        drive1(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        drive1(1'b1, 1'b0, 2'b11, 32'h20, 32'h0);
        tick();
        check("mis_rd_ack1",  {31'b0, ack_1}, 32'h1);
        check("mis_rd_err1",  {31'b0, err_1}, 32'h0);
        check("mis_rd_rdata", rdata_1, 32'h55AA55AA);
        check("mis_rd_r0",    rdata_0, 32'h0);
        drive1(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        check("p1_gcnt1", {28'b0, gcnt1}, 32'h3);

        // Both ports requesting out of reset: 0,1,0,1,0,1 with no gap.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive0(1'b1, 1'b0, 2'b11, 32'h10, 32'h0);
        drive1(1'b1, 1'b0, 2'b11, 32'h20, 32'h0);
        tick();
        for (int i = 0; i < 6; i++) begin
            check($sformatf("rr_ack0_%0d", i), {31'b0, ack_0}, {31'b0, (i % 2 == 0)});
            check($sformatf("rr_ack1_%0d", i), {31'b0, ack_1}, {31'b0, (i % 2 == 1)});
            if (i == 4) drive0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
            if (i == 5) drive1(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
            tick();
        end
        check("rr_idle",  {30'b0, ack_1, ack_0}, 32'h0);
        check("rr_gcnt0", {28'b0, gcnt0}, 32'h3);
        check("rr_gcnt1", {28'b0, gcnt1}, 32'h3);

        // Reset in the middle of a write's SERVE cycle.
        drive0(1'b1, 1'b1, 2'b11, 32'h30, 32'h0BADF00D);
        tick();
        drive0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        check("pre_mem", mem[12], 32'h0BADF00D);
        drive0(1'b1, 1'b1, 2'b11, 32'h30, 32'h12345678);
        tick();
        check("mid_scr_before", {31'b0, dm_scr}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_scr_after", {31'b0, dm_scr}, 32'h0);
        check("mid_ack0",      {31'b0, ack_0}, 32'h0);
        check("mid_addr",      dm_addr, 32'h0);
        tick();
        drive0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        reset = 1'b0;
        tick();
        check("mid_mem",   mem[12], 32'h0BADF00D);
        check("mid_gcnt0", {28'b0, gcnt0}, 32'h0);
        check("mid_gcnt1", {28'b0, gcnt1}, 32'h0);

        // 19 grants to port 0 with a 4-bit counter saturate at 0xF.
        drive0(1'b1, 1'b0, 2'b11, 32'h10, 32'h0);
        for (int k = 1; k <= 19; k++) begin
            tick();
            tick();
            if (k == 14) check("sat_gcnt0_14", {28'b0, gcnt0}, 32'hE);
            if (k == 15) check("sat_gcnt0_15", {28'b0, gcnt0}, 32'hF);
        end
        drive0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        check("sat_gcnt0_19", {28'b0, gcnt0}, 32'hF);
        check("sat_gcnt1",    {28'b0, gcnt1}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
